// File: rtl/led_pwm_ctrl_pkg.sv
// Shared definitions for the LED PWM peripheral: register addresses,
// duty-write index field position and the per-channel mode encoding.
package led_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_LED   = 2'd0;
    localparam reg_addr_t ADDR_MODE  = 2'd1;
    localparam reg_addr_t ADDR_DUTY  = 2'd2;
    localparam reg_addr_t ADDR_BLINK = 2'd3;

    localparam int DUTY_IDX_MSB = 15;
    localparam int DUTY_IDX_LSB = 12;
    localparam int DUTY_IDX_W   = DUTY_IDX_MSB - DUTY_IDX_LSB + 1;

    typedef logic [DUTY_IDX_W-1:0] duty_idx_t;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_PWM    = 1'b1
    } led_mode_e;

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// d16 I/O bus slice seen by the LED peripheral: select, direction,
// word address, write data and registered read data.
interface led_pwm_ctrl_if;
    import led_pkg::*;

    logic        en;
    logic        wr_en;
    reg_addr_t   addr;
    logic [15:0] data;
    logic [15:0] data_out;

    modport master (output en, wr_en, addr, data, input data_out);
    modport slave  (input en, wr_en, addr, data, output data_out);

endinterface

// File: rtl/led_pwm_chan.sv
// One LED channel: combines static enable, PWM compare and blink gate
// into a registered pin drive.
module led_pwm_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    input  led_mode_e           mode,
    input  logic                on,
    input  logic                gate,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    logic pwm_on;

    // Duty 0 never matches, full-scale duty drops exactly one count per period.
    assign pwm_on = (mode == MODE_PWM) ? (pwm_cnt < duty) : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= on & pwm_on & gate;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED peripheral: static mask, per-channel PWM and readback.
// Define LED_BLINK_EN to build the blink mask register and its prescaler.
module led_pwm_ctrl
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int PWM_BITS       = 8,
    parameter int BLINK_DIV_LOG2 = 22
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_ctrl_if.slave       bus,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_LEDS-1:0] mode_reg;
    logic [NUM_LEDS-1:0] blink_gate;
    logic [NUM_LEDS-1:0] blink_rd;
    logic [PWM_BITS-1:0] duty_reg [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_rd;
    logic [PWM_BITS-1:0] pwm_cnt;
    duty_idx_t           duty_idx;
    duty_idx_t           wr_idx;
    logic [15:0]         rd_word;
    logic                wr_stb;
    logic                rd_stb;
    logic                idx_ok;
    logic                unused_bits;

    assign wr_stb = bus.en & bus.wr_en;
    assign rd_stb = bus.en & ~bus.wr_en;
    assign wr_idx = bus.data[DUTY_IDX_MSB:DUTY_IDX_LSB];
    assign idx_ok = (32'(wr_idx) < NUM_LEDS);

    // Upper data bits beyond the configured widths are don't-care.
    assign unused_bits = ^{bus.data, BLINK_DIV_LOG2[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg  <= '0;
            mode_reg <= '0;
            duty_idx <= '0;
            // NOTE: the duty array is cleared explicitly; it is a handful of flops, not a RAM.
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_reg[i] <= '0;
            end
        end else if (wr_stb) begin
            case (bus.addr)
                ADDR_LED:  led_reg  <= bus.data[NUM_LEDS-1:0];
                ADDR_MODE: mode_reg <= bus.data[NUM_LEDS-1:0];
                ADDR_DUTY: begin
                    if (idx_ok) begin
                        duty_idx <= wr_idx;
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (wr_idx == duty_idx_t'(i)) begin
                                duty_reg[i] <= bus.data[PWM_BITS-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        duty_rd = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (duty_idx == duty_idx_t'(i)) begin
                duty_rd = duty_reg[i];
            end
        end
        case (bus.addr)
            ADDR_LED:   rd_word[NUM_LEDS-1:0] = led_reg;
            ADDR_MODE:  rd_word[NUM_LEDS-1:0] = mode_reg;
            ADDR_DUTY:  rd_word[PWM_BITS-1:0] = duty_rd;
            ADDR_BLINK: rd_word[NUM_LEDS-1:0] = blink_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
        end else if (rd_stb) begin
            bus.data_out <= rd_word;
        end
    end

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

`ifdef LED_BLINK_EN
    logic [NUM_LEDS-1:0]       blink_reg;
    logic [BLINK_DIV_LOG2-1:0] blink_presc;
    logic                      blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_reg   <= '0;
            blink_presc <= '0;
            blink_phase <= 1'b1;
        end else begin
            blink_presc <= blink_presc + BLINK_DIV_LOG2'(1);
            if (&blink_presc) begin
                blink_phase <= ~blink_phase;
            end
            if (wr_stb && bus.addr == ADDR_BLINK) begin
                blink_reg <= bus.data[NUM_LEDS-1:0];
            end
        end
    end

    assign blink_gate = ~blink_reg | {NUM_LEDS{blink_phase}};
    assign blink_rd   = blink_reg;
`else
    assign blink_gate = '1;
    assign blink_rd   = '0;
`endif

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .duty    (duty_reg[g]),
            .mode    (led_mode_e'(mode_reg[g])),
            .on      (led_reg[g]),
            .gate    (blink_gate[g]),
            .pwm_cnt (pwm_cnt),
            .led     (led_out[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: directed scenarios with literal
// expectations plus randomized bus traffic checked every cycle against a model.
module tb_led_pwm_ctrl;
    import led_pkg::*;

    localparam int NUM_LEDS       = 8;
    localparam int PWM_BITS       = 8;
    localparam int BLINK_DIV_LOG2 = 4;
    localparam int PERIOD         = 1 << PWM_BITS;
    localparam int HALF           = 1 << BLINK_DIV_LOG2;
`ifdef LED_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_LEDS-1:0] led_out;

    led_pwm_ctrl_if bus ();

    led_pwm_ctrl #(
        .NUM_LEDS       (NUM_LEDS),
        .PWM_BITS       (PWM_BITS),
        .BLINK_DIV_LOG2 (BLINK_DIV_LOG2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus the number of clock edges since reset.
    // The PWM count and blink phase follow directly from that edge count.
    logic [NUM_LEDS-1:0] m_led, m_mode, m_blink;
    logic [PWM_BITS-1:0] m_duty [NUM_LEDS];
    int                  m_idx;
    int                  m_edges;
    logic [NUM_LEDS-1:0] exp_led;
    logic [15:0]         exp_data;
    bit                  model_ok = 1'b0;

    function automatic logic [15:0] model_read(input reg_addr_t a);
        logic [15:0] w = '0;
        case (a)
            ADDR_LED:   w[NUM_LEDS-1:0] = m_led;
            ADDR_MODE:  w[NUM_LEDS-1:0] = m_mode;
            ADDR_DUTY:  w[PWM_BITS-1:0] = m_duty[m_idx];
            ADDR_BLINK: w[NUM_LEDS-1:0] = BLINK_BUILT ? m_blink : '0;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_led    = '0;
            m_mode   = '0;
            m_blink  = '0;
            m_idx    = 0;
            m_edges  = 0;
            exp_led  = '0;
            exp_data = '0;
            for (int i = 0; i < NUM_LEDS; i++) m_duty[i] = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                bit pwm_ok, gate_ok;
                pwm_ok  = !m_mode[i] || ((m_edges % PERIOD) < int'(m_duty[i]));
                gate_ok = !BLINK_BUILT || !m_blink[i] || (((m_edges / HALF) % 2) == 0);
                exp_led[i] = m_led[i] && pwm_ok && gate_ok;
            end
            if (bus.en && !bus.wr_en) exp_data = model_read(bus.addr);
            if (bus.en && bus.wr_en) begin
                case (bus.addr)
                    ADDR_LED:   m_led   = bus.data[NUM_LEDS-1:0];
                    ADDR_MODE:  m_mode  = bus.data[NUM_LEDS-1:0];
                    ADDR_BLINK: m_blink = bus.data[NUM_LEDS-1:0];
                    ADDR_DUTY: begin
                        int ch;
                        ch = int'(bus.data[15:12]);
                        if (ch < NUM_LEDS) begin
                            m_duty[ch] = bus.data[PWM_BITS-1:0];
                            m_idx      = ch;
                        end
                    end
                endcase
            end
            m_edges++;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (model_ok) begin
            check("led_out_vs_model", 16'(led_out), 16'(exp_led));
            check("data_out_vs_model", bus.data_out, exp_data);
        end
    end

    task automatic wr(input reg_addr_t a, input logic [15:0] d);
        bus.en = 1'b1; bus.wr_en = 1'b1; bus.addr = a; bus.data = d;
        @(negedge clk);
        bus.en = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic rd(input reg_addr_t a);
        bus.en = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic count_high(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            cnt += int'(led_out[ch]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt0, cnt7;

    initial begin
        rst = 1'b1;
        bus.en = 1'b1; bus.wr_en = 1'b1; bus.addr = ADDR_LED; bus.data = 16'hFFFF;

        // Reset held with a pending write on the bus.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_led_out", 16'(led_out), 16'h0000);
            check("rst_data_out", bus.data_out, 16'h0000);
        end
        rst = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0; bus.data = 16'h0000;
        @(negedge clk);
        check("post_rst_led_out", 16'(led_out), 16'h0000);
        check("post_rst_data_out", bus.data_out, 16'h0000);

        // Static mask: visible on the second edge after the write.
        wr(ADDR_MODE, 16'h0000);
        wr(ADDR_LED, 16'h00A5);
        check("static_one_edge", 16'(led_out), 16'h0000);
        @(negedge clk);
        check("static_two_edges", 16'(led_out), 16'h00A5);
        rd(ADDR_LED);
        check("read_led", bus.data_out, 16'h00A5);

        // PWM duty 64, 0 and 255 on channel 0.
        wr(ADDR_LED, 16'h0001);
        wr(ADDR_MODE, 16'h0001);
        wr(ADDR_DUTY, 16'h0040);
        repeat (2) @(negedge clk);
        count_high(0, PERIOD, cnt0);
        check("duty64_count", 16'(cnt0), 16'd64);
        wr(ADDR_DUTY, 16'h0000);
        repeat (2) @(negedge clk);
        count_high(0, PERIOD, cnt0);
        check("duty0_count", 16'(cnt0), 16'd0);
        wr(ADDR_DUTY, 16'h00FF);
        repeat (2) @(negedge clk);
        count_high(0, PERIOD, cnt0);
        check("duty255_count", 16'(cnt0), 16'd255);

        // Indexed duty bounds.
        wr(ADDR_DUTY, 16'h0033);
        wr(ADDR_DUTY, 16'hF080);
        rd(ADDR_DUTY);
        check("duty_oob_ignored", bus.data_out, 16'h0033);
        wr(ADDR_DUTY, 16'h7010);
        rd(ADDR_DUTY);
        check("duty_ch7_read", bus.data_out, 16'h0010);
        wr(ADDR_LED, 16'h0081);
        wr(ADDR_MODE, 16'h0081);
        repeat (2) @(negedge clk);
        cnt0 = 0; cnt7 = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            cnt0 += int'(led_out[0]);
            cnt7 += int'(led_out[7]);
        end
        check("ch0_duty_kept", 16'(cnt0), 16'd51);
        check("ch7_duty16", 16'(cnt7), 16'd16);

        // Reset wins over a simultaneous write.
        rst = 1'b1;
        bus.en = 1'b1; bus.wr_en = 1'b1; bus.addr = ADDR_LED; bus.data = 16'h00FF;
        @(negedge clk);
        rst = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check("prio_led_out", 16'(led_out), 16'h0000);
        rd(ADDR_LED);
        check("prio_led_reg", bus.data_out, 16'h0000);

`ifdef LED_BLINK_EN
        do_reset();
        wr(ADDR_LED, 16'h0003);
        wr(ADDR_BLINK, 16'h0002);
        repeat (2) @(negedge clk);
        cnt0 = 0; cnt7 = 0;
        for (int k = 0; k < 4 * HALF; k++) begin
            @(negedge clk);
            cnt0 += int'(led_out[0]);
            cnt7 += int'(led_out[1]);
        end
        check("blink_ch0_steady", 16'(cnt0), 16'(4 * HALF));
        check("blink_ch1_half", 16'(cnt7), 16'(2 * HALF));
        rd(ADDR_BLINK);
        check("blink_read", bus.data_out, 16'h0002);
`else
        wr(ADDR_BLINK, 16'hFFFF);
        rd(ADDR_BLINK);
        check("blink_absent_read", bus.data_out, 16'h0000);
`endif

        // Randomized bus traffic with occasional reset; the model checks every cycle.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 299) == 0);
            bus.en    = ($urandom_range(0, 2) != 0);
            bus.wr_en = $urandom_range(0, 1) == 1;
            bus.addr  = reg_addr_t'($urandom_range(0, 3));
            bus.data  = 16'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
